// File: rtl/pic_pkg.sv
// Shared definitions for the PIC / CPU interrupt-acknowledge logic:
// sequencer state encoding, INTA count codes and a small constant helper.
package pic_pkg;

    // Acknowledge sequencer states
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ACK1    = 3'd1;
    localparam logic [2:0] ST_GAP     = 3'd2;
    localparam logic [2:0] ST_ACK2    = 3'd3;
    localparam logic [2:0] ST_DELIVER = 3'd4;

    // INTA count seen by the PIC IRR/ISR stepping logic
    localparam logic [1:0] INTA_NONE   = 2'b00;
    localparam logic [1:0] INTA_FIRST  = 2'b01;
    localparam logic [1:0] INTA_SECOND = 2'b10;

    // Larger of two integers, used to size the shared pulse/gap counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// All stages clear to 0 on reset.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input one stage deeper each cycle
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchronizer flop chain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/inta_sequencer.sv
// CPU-side interrupt acknowledge sequencer. Watches INT from the PIC, runs the
// two-pulse INTA sequence, captures the vector during INTA2 and hands it to
// the core over a valid/ready handshake. All outputs come straight from flops.
import pic_pkg::*;

module inta_sequencer #(
    parameter int PULSE_W     = 2,
    parameter int GAP_W       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       int_req,
    input  logic       int_enable,
    input  logic [7:0] data_in,
    output logic       inta_n,
    output logic [1:0] inta_count,
    output logic       lock,
    output logic       busy,
    output logic [7:0] vector,
    output logic       vector_valid,
    input  logic       vector_ready
);

    localparam int CNT_W = $clog2(max_int(PULSE_W, GAP_W)) + 1;
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic             int_sync_s;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       vector_q, vector_d;
    logic             inta_n_q, inta_n_d;
    logic [1:0]       inta_count_q, inta_count_d;
    logic             lock_q, lock_d;
    logic             busy_q, busy_d;
    logic             vector_valid_q, vector_valid_d;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_int_sync (
        .clk   (clk),
        .reset (reset),
        .d     (int_req),
        .q     (int_sync_s)
    );

    // Next state, per-state cycle counter and vector capture; once ACK1 is
    // entered the sequence runs to DELIVER regardless of int_req/int_enable
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vector_d = vector_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (int_sync_s && int_enable) begin
                    state_d = ST_ACK1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK1: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_ACK2;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_ACK2: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d  = ST_DELIVER;
                    cnt_d    = '0;
                    vector_d = data_in;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DELIVER: begin
                cnt_d = '0;
                if (vector_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DELIVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Decode outputs from the upcoming state so they can be registered
    // without adding a cycle of latency
    always_comb begin
        inta_n_d       = 1'b1;
        inta_count_d   = INTA_NONE;
        lock_d         = 1'b0;
        busy_d         = (state_d != ST_IDLE);
        vector_valid_d = 1'b0;
        case (state_d)
            ST_ACK1: begin
                inta_n_d     = 1'b0;
                inta_count_d = INTA_FIRST;
                lock_d       = 1'b1;
            end
            ST_GAP: begin
                inta_count_d = INTA_FIRST;
                lock_d       = 1'b1;
            end
            ST_ACK2: begin
                inta_n_d     = 1'b0;
                inta_count_d = INTA_SECOND;
                lock_d       = 1'b1;
            end
            ST_DELIVER: begin
                vector_valid_d = 1'b1;
            end
            default: begin
                inta_n_d = 1'b1;
            end
        endcase
    end

    // Sequencer state, counter and vector register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            vector_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vector_q <= vector_d;
        end
    end

    // Output flops; reset drops the strobe and any pending vector at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inta_n_q       <= 1'b1;
            inta_count_q   <= INTA_NONE;
            lock_q         <= 1'b0;
            busy_q         <= 1'b0;
            vector_valid_q <= 1'b0;
        end else begin
            inta_n_q       <= inta_n_d;
            inta_count_q   <= inta_count_d;
            lock_q         <= lock_d;
            busy_q         <= busy_d;
            vector_valid_q <= vector_valid_d;
        end
    end

    assign inta_n       = inta_n_q;
    assign inta_count   = inta_count_q;
    assign lock         = lock_q;
    assign busy         = busy_q;
    assign vector       = vector_q;
    assign vector_valid = vector_valid_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Testbench for inta_sequencer: default-parameter instance checked against a
// timeline-based reference model, plus a PULSE_W=1/GAP_W=3 instance checked
// against a fixed expected waveform.
module tb_inta_sequencer;

    localparam int P       = 2;
    localparam int G       = 2;
    localparam int S       = 2;
    localparam int SEQ_LEN = 2 * P + G;

    logic       clk          = 1'b0;
    logic       reset        = 1'b1;
    logic       int_req      = 1'b0;
    logic       int_enable   = 1'b0;
    logic       vector_ready = 1'b0;
    logic [7:0] data_in      = 8'h00;
    logic       inta_n;
    logic [1:0] inta_count;
    logic       lock;
    logic       busy;
    logic [7:0] vector;
    logic       vector_valid;

    logic       int_req2      = 1'b0;
    logic       int_enable2   = 1'b0;
    logic       vector_ready2 = 1'b0;
    logic       inta_n2;
    logic [1:0] inta_count2;
    logic       lock2;
    logic       busy2;
    logic [7:0] vector2;
    logic       vector_valid2;

    logic [13:0] dut_out;
    logic [13:0] dut2_out;
    assign dut_out  = {inta_n, inta_count, lock, busy, vector_valid, vector};
    assign dut2_out = {inta_n2, inta_count2, lock2, busy2, vector_valid2, vector2};

    int tests_run    = 0;
    int tests_failed = 0;

    inta_sequencer #(.PULSE_W(P), .GAP_W(G), .SYNC_STAGES(S)) dut (
        .clk          (clk),
        .reset        (reset),
        .int_req      (int_req),
        .int_enable   (int_enable),
        .data_in      (data_in),
        .inta_n       (inta_n),
        .inta_count   (inta_count),
        .lock         (lock),
        .busy         (busy),
        .vector       (vector),
        .vector_valid (vector_valid),
        .vector_ready (vector_ready)
    );

    inta_sequencer #(.PULSE_W(1), .GAP_W(3), .SYNC_STAGES(2)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .int_req      (int_req2),
        .int_enable   (int_enable2),
        .data_in      (data_in),
        .inta_n       (inta_n2),
        .inta_count   (inta_count2),
        .lock         (lock2),
        .busy         (busy2),
        .vector       (vector2),
        .vector_valid (vector_valid2),
        .vector_ready (vector_ready2)
    );

    always #5 clk = ~clk;

    // Reference model: m_pos is the cycle index since ACK1 entry (-1 = none)
    bit         m_req_q[$];
    int         m_pos;
    bit         m_deliver;
    logic [7:0] m_vec;

    task automatic model_reset();
        m_req_q = {};
        for (int i = 0; i < S; i++) m_req_q.push_back(1'b0);
        m_pos     = -1;
        m_deliver = 1'b0;
        m_vec     = 8'h00;
    endtask

    // Advance the model across one rising edge using the current inputs
    task automatic model_update();
        bit sync_prev;
        sync_prev = m_req_q[0];
        if (m_deliver) begin
            if (vector_ready) m_deliver = 1'b0;
        end else if (m_pos >= 0) begin
            if (m_pos == SEQ_LEN - 1) begin
                m_vec     = data_in;
                m_deliver = 1'b1;
                m_pos     = -1;
            end else begin
                m_pos++;
            end
        end else if (sync_prev && int_enable) begin
            m_pos = 0;
        end
        m_req_q.push_back(int_req);
        void'(m_req_q.pop_front());
    endtask

    function automatic logic [13:0] model_out();
        logic       n;
        logic [1:0] c;
        logic       lk;
        logic       bz;
        n  = !((m_pos >= 0 && m_pos < P) || (m_pos >= P + G && m_pos < SEQ_LEN));
        c  = (m_pos >= 0 && m_pos < P + G) ? 2'b01 : ((m_pos >= P + G) ? 2'b10 : 2'b00);
        lk = (m_pos >= 0);
        bz = lk || m_deliver;
        return {n, c, lk, bz, m_deliver, m_vec};
    endfunction

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        int_req      = 1'b0;
        int_enable   = 1'b0;
        vector_ready = 1'b0;
        int_req2     = 1'b0;
        int_enable2  = 1'b0;
        vector_ready2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        tests_run++;
        if (dut_out !== {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            tests_failed++;
            $display("FAIL reset_state: got %h expected %h", dut_out, 14'h2000);
        end
        tests_run++;
        if (dut2_out !== {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            tests_failed++;
            $display("FAIL reset_state2: got %h expected %h", dut2_out, 14'h2000);
        end
        do_reset();
    endtask

    task automatic test_single_irq();
        do_reset();
        data_in      = 8'h0B;
        vector_ready = 1'b1;
        int_enable   = 1'b1;
        int_req      = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            if (i == 4) int_req = 1'b0;
            step();
            tests_run++;
            if (dut_out !== model_out()) begin
                tests_failed++;
                $display("FAIL single_irq cyc %0d: got %h expected %h", i, dut_out, model_out());
            end
            tests_run++;
            if (inta_n !== !(i == 3 || i == 4 || i == 7 || i == 8) ||
                vector_valid !== (i == 9)) begin
                tests_failed++;
                $display("FAIL single_irq_timing cyc %0d: got inta_n=%b valid=%b", i, inta_n, vector_valid);
            end
        end
        tests_run++;
        if (vector !== 8'h0B) begin
            tests_failed++;
            $display("FAIL single_irq_vector: got %h expected 0b", vector);
        end
    endtask

    task automatic test_stalled();
        int n;
        do_reset();
        data_in      = 8'h5A;
        vector_ready = 1'b0;
        int_enable   = 1'b1;
        int_req      = 1'b1;
        n = 0;
        while (!m_deliver && n < 20) begin
            step();
            n++;
            tests_run++;
            if (dut_out !== model_out()) begin
                tests_failed++;
                $display("FAIL stall_run cyc %0d: got %h expected %h", n, dut_out, model_out());
            end
        end
        tests_run++;
        if (!m_deliver || vector_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_reach_deliver: got valid=%b expected 1", vector_valid);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if (dut_out !== model_out() || vector !== 8'h5A || inta_n !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall_hold cyc %0d: got %h expected %h", i, dut_out, model_out());
            end
        end
        vector_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            vector_ready = 1'b0;
            tests_run++;
            if (dut_out !== model_out()) begin
                tests_failed++;
                $display("FAIL stall_accept cyc %0d: got %h expected %h", i, dut_out, model_out());
            end
            tests_run++;
            if ((i == 0 && busy !== 1'b0) || (i == 1 && inta_n !== 1'b0)) begin
                tests_failed++;
                $display("FAIL stall_b2b cyc %0d: got busy=%b inta_n=%b", i, busy, inta_n);
            end
        end
        int_req = 1'b0;
    endtask

    task automatic test_enable_gate();
        do_reset();
        vector_ready = 1'b1;
        int_enable   = 1'b0;
        int_req      = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            tests_run++;
            if (dut_out !== model_out() || inta_n !== 1'b1 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL enable_gate cyc %0d: got %h expected %h", i, dut_out, model_out());
            end
        end
        int_enable = 1'b1;
        step();
        tests_run++;
        if (dut_out !== model_out() || inta_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL enable_start: got %h expected %h", dut_out, model_out());
        end
        int_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            tests_run++;
            if (dut_out !== model_out()) begin
                tests_failed++;
                $display("FAIL enable_drain cyc %0d: got %h expected %h", i, dut_out, model_out());
            end
        end
    endtask

    task automatic test_drop_in_gap();
        int  n;
        bit  seen;
        do_reset();
        data_in      = 8'h0F;
        vector_ready = 1'b1;
        int_enable   = 1'b1;
        int_req      = 1'b1;
        n = 0;
        while (m_pos != P && n < 20) begin
            step();
            n++;
        end
        int_req    = 1'b0;
        int_enable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (vector_valid === 1'b1 && vector === 8'h0F) seen = 1'b1;
            tests_run++;
            if (dut_out !== model_out()) begin
                tests_failed++;
                $display("FAIL drop_gap cyc %0d: got %h expected %h", i, dut_out, model_out());
            end
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL drop_gap_deliver: got vector %h expected 0f delivered", vector);
        end
    endtask

    task automatic test_async_reset();
        int n;
        bit seen;
        do_reset();
        data_in      = 8'hE7;
        vector_ready = 1'b1;
        int_enable   = 1'b1;
        int_req      = 1'b1;
        n = 0;
        while (m_pos != P + G && n < 20) begin
            step();
            n++;
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({inta_n, lock, vector_valid, busy} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL async_reset: got inta_n/lock/valid/busy=%b expected 1000",
                     {inta_n, lock, vector_valid, busy});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        data_in = 8'h3C;
        seen    = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (vector_valid === 1'b1 && vector !== 8'h3C) seen = 1'b1;
            tests_run++;
            if (dut_out !== model_out()) begin
                tests_failed++;
                $display("FAIL async_recover cyc %0d: got %h expected %h", i, dut_out, model_out());
            end
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("FAIL async_partial: got a delivered vector other than 3c");
        end
        int_req = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            int_req      = ($urandom_range(0, 3) != 0);
            int_enable   = ($urandom_range(0, 4) != 0);
            vector_ready = ($urandom_range(0, 2) == 0);
            data_in      = 8'($urandom);
            step();
            tests_run++;
            if (dut_out !== model_out()) begin
                tests_failed++;
                $display("FAIL random cyc %0d: got %h expected %h", i, dut_out, model_out());
            end
        end
    endtask

    task automatic test_short_pulse();
        int en_n[6];
        int ec[6];
        int ev[6];
        int w;
        bit found;
        en_n = '{0, 1, 1, 1, 0, 1};
        ec   = '{1, 1, 1, 1, 2, 0};
        ev   = '{0, 0, 0, 0, 0, 1};
        do_reset();
        data_in       = 8'hA5;
        int_enable2   = 1'b1;
        vector_ready2 = 1'b1;
        int_req2      = 1'b1;
        found = 1'b0;
        w = 0;
        while (!found && w < 10) begin
            @(posedge clk);
            #1;
            w++;
            if (inta_n2 === 1'b0) found = 1'b1;
        end
        tests_run++;
        if (!found || w != 3) begin
            tests_failed++;
            $display("FAIL short_latency: got %0d cycles expected 3", w);
        end
        if (found) begin
            for (int j = 0; j < 6; j++) begin
                if (j > 0) begin
                    @(posedge clk);
                    #1;
                end
                tests_run++;
                if ({inta_n2, inta_count2, vector_valid2} !== {1'(en_n[j]), 2'(ec[j]), 1'(ev[j])}) begin
                    tests_failed++;
                    $display("FAIL short_wave cyc %0d: got %b expected %b", j,
                             {inta_n2, inta_count2, vector_valid2}, {1'(en_n[j]), 2'(ec[j]), 1'(ev[j])});
                end
            end
            tests_run++;
            if (vector2 !== 8'hA5) begin
                tests_failed++;
                $display("FAIL short_vector: got %h expected a5", vector2);
            end
        end
        int_req2 = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_irq();
        test_stalled();
        test_enable_gate();
        test_drop_in_gap();
        test_async_reset();
        test_random();
        test_short_pulse();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
